// File: rtl/vga_if.sv
// rtl/vga_if.sv - VGA timing/pixel bundle passed between draw stages
interface vga_if;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hblnk;
    logic        vblnk;
    logic        hsync;
    logic        vsync;
    logic [11:0] rgb;

    modport in  (input  hcount, vcount, hblnk, vblnk, hsync, vsync, rgb);
    modport out (output hcount, vcount, hblnk, vblnk, hsync, vsync, rgb);
endinterface

// File: rtl/draw_rect.sv
// rtl/draw_rect.sv - two-stage overlay painting a solid rectangle; DRAW_RECT_FRAME_LATCH_EN latches position at vblank
module draw_rect #(
    parameter int unsigned RECT_W     = 48,
    parameter int unsigned RECT_H     = 64,
    parameter logic [11:0] RECT_COLOR = 12'hF0F
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] xpos,
    input  logic [11:0] ypos,
    vga_if.in           vga_in,
    vga_if.out          vga_out
);
    localparam logic [12:0] W13 = 13'(RECT_W);
    localparam logic [12:0] H13 = 13'(RECT_H);

    logic [11:0] xa;
    logic [11:0] ya;

`ifdef DRAW_RECT_FRAME_LATCH_EN
    // Position is sampled once per frame at the start of vertical blank so the
    // rectangle never tears while the beam is in the active area.
    logic vblnk_prev;

    always_ff @(posedge clk) begin
        if (!rst) begin
            xa         <= 12'd0;
            ya         <= 12'd0;
            vblnk_prev <= 1'b0;
        end else begin
            if (vga_in.vblnk && !vblnk_prev) begin
                xa <= xpos;
                ya <= ypos;
            end
            vblnk_prev <= vga_in.vblnk;
        end
    end
`else
    assign xa = xpos;
    assign ya = ypos;
`endif

    logic [12:0] h13;
    logic [12:0] v13;
    logic [12:0] x_end;
    logic [12:0] y_end;
    logic        hit;

    // 13-bit sums keep a rectangle near the right/bottom edge from wrapping to 0.
    always_comb begin
        h13   = {2'b00, vga_in.hcount};
        v13   = {2'b00, vga_in.vcount};
        x_end = {1'b0, xa} + W13;
        y_end = {1'b0, ya} + H13;
        hit   = (h13 >= {1'b0, xa}) && (h13 < x_end) &&
                (v13 >= {1'b0, ya}) && (v13 < y_end);
    end

    logic [10:0] hcount_s1;
    logic [10:0] vcount_s1;
    logic        hblnk_s1;
    logic        vblnk_s1;
    logic        hsync_s1;
    logic        vsync_s1;
    logic [11:0] rgb_s1;
    logic        hit_s1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            hcount_s1 <= 11'd0;
            vcount_s1 <= 11'd0;
            hblnk_s1  <= 1'b0;
            vblnk_s1  <= 1'b0;
            hsync_s1  <= 1'b0;
            vsync_s1  <= 1'b0;
            rgb_s1    <= 12'h000;
            hit_s1    <= 1'b0;
        end else begin
            hcount_s1 <= vga_in.hcount;
            vcount_s1 <= vga_in.vcount;
            hblnk_s1  <= vga_in.hblnk;
            vblnk_s1  <= vga_in.vblnk;
            hsync_s1  <= vga_in.hsync;
            vsync_s1  <= vga_in.vsync;
            rgb_s1    <= vga_in.rgb;
            hit_s1    <= hit;
        end
    end

    logic [11:0] rgb_nxt;

    always_comb begin
        rgb_nxt = rgb_s1;
        if (hblnk_s1 || vblnk_s1) begin
            rgb_nxt = 12'h000;
        end else if (hit_s1) begin
            rgb_nxt = RECT_COLOR;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            vga_out.hcount <= 11'd0;
            vga_out.vcount <= 11'd0;
            vga_out.hblnk  <= 1'b0;
            vga_out.vblnk  <= 1'b0;
            vga_out.hsync  <= 1'b0;
            vga_out.vsync  <= 1'b0;
            vga_out.rgb    <= 12'h000;
        end else begin
            vga_out.hcount <= hcount_s1;
            vga_out.vcount <= vcount_s1;
            vga_out.hblnk  <= hblnk_s1;
            vga_out.vblnk  <= vblnk_s1;
            vga_out.hsync  <= hsync_s1;
            vga_out.vsync  <= vsync_s1;
            vga_out.rgb    <= rgb_nxt;
        end
    end
endmodule

// File: tb/tb_draw_rect.sv
// tb/tb_draw_rect.sv - self-checking bench for draw_rect against a delayed-stream pixel model
module tb_draw_rect;
    typedef struct packed {
        logic [10:0] h;
        logic [10:0] v;
        logic        hb;
        logic        vb;
        logic        hs;
        logic        vs;
        logic [11:0] rgb;
    } pix_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [11:0] xpos = 12'd0;
    logic [11:0] ypos = 12'd0;
    logic [11:0] bg = 12'h0A0;
    int          phase = 1;
    int          errors = 0;
    int          checks = 0;

    vga_if vin ();
    vga_if vout ();

    draw_rect dut (
        .clk     (clk),
        .rst     (rst),
        .xpos    (xpos),
        .ypos    (ypos),
        .vga_in  (vin),
        .vga_out (vout)
    );

    always #5 clk = ~clk;

    // Literal expectations: phase, column, line, colour.
    localparam int NLIT = 21;
    int          lit_ph [NLIT];
    int          lit_h  [NLIT];
    int          lit_v  [NLIT];
    logic [11:0] lit_c  [NLIT];
    bit          lit_seen [NLIT];
    bit          first_seen = 1'b0;
    int          f0f_count = 0;

    task automatic set_lit(input int i, input int ph, input int h, input int v, input logic [11:0] c);
        lit_ph[i] = ph; lit_h[i] = h; lit_v[i] = v; lit_c[i] = c; lit_seen[i] = 1'b0;
    endtask

    function automatic pix_t model_out(input pix_t p, input int px, input int py);
        pix_t r;
        bit   hit;
        r   = p;
        hit = (int'(p.h) >= px) && (int'(p.h) < px + 48) &&
              (int'(p.v) >= py) && (int'(p.v) < py + 64);
        if (p.hb || p.vb)
            r.rgb = 12'h000;
        else if (hit)
            r.rgb = 12'hF0F;
        return r;
    endfunction

    task automatic pix(input int h, input int v);
        vin.hcount = 11'(h);
        vin.vcount = 11'(v);
        vin.hblnk  = (h >= 800);
        vin.vblnk  = (v >= 600);
        vin.hsync  = (h >= 840) && (h < 968);
        vin.vsync  = (v >= 601) && (v < 605);
        vin.rgb    = bg;
        @(posedge clk);
        #1;
    endtask

    task automatic drive_line(input int v);
        for (int h = 0; h < 160; h++) pix(h, v);
        for (int h = 290; h <= 360; h++) pix(h, v);
        for (int h = 760; h < 860; h++) pix(h, v);
    endtask

    task automatic drive_full(input int v);
        for (int h = 0; h < 1056; h++) pix(h, v);
    endtask

    task automatic start_frame(input int x, input int y);
        xpos = 12'(x);
        ypos = 12'(y);
        pix(0, 599);
        pix(0, 600);
        pix(1, 600);
    endtask

    // Model and per-cycle compare
    initial begin
        pix_t cur_in, prev_in, exp_p, got;
        logic cur_rst, prev_rst;
        int   cur_px, cur_py, prev_px, prev_py;
        int   m_xa, m_ya;
        bit   m_vprev;
        prev_rst = 1'b0; prev_in = '0; prev_px = 0; prev_py = 0;
        m_xa = 0; m_ya = 0; m_vprev = 1'b0;
        forever begin
            @(posedge clk);
            cur_in  = {vin.hcount, vin.vcount, vin.hblnk, vin.vblnk, vin.hsync, vin.vsync, vin.rgb};
            cur_rst = rst;
`ifdef DRAW_RECT_FRAME_LATCH_EN
            cur_px = m_xa;
            cur_py = m_ya;
            if (!cur_rst) begin
                m_xa = 0; m_ya = 0; m_vprev = 1'b0;
            end else begin
                if (cur_in.vb && !m_vprev) begin
                    m_xa = int'(xpos); m_ya = int'(ypos);
                end
                m_vprev = cur_in.vb;
            end
`else
            cur_px = int'(xpos);
            cur_py = int'(ypos);
`endif
            exp_p    = (!cur_rst || !prev_rst) ? pix_t'('0) : model_out(prev_in, prev_px, prev_py);
            prev_in  = cur_in;
            prev_rst = cur_rst;
            prev_px  = cur_px;
            prev_py  = cur_py;
            #1;
            got = {vout.hcount, vout.vcount, vout.hblnk, vout.vblnk, vout.hsync, vout.vsync, vout.rgb};
            checks++;
            if (got !== exp_p) begin
                errors++;
                $display("FAIL pipe phase=%0d got h=%0d v=%0d hb=%b vb=%b hs=%b vs=%b rgb=%h required h=%0d v=%0d hb=%b vb=%b hs=%b vs=%b rgb=%h",
                         phase, got.h, got.v, got.hb, got.vb, got.hs, got.vs, got.rgb,
                         exp_p.h, exp_p.v, exp_p.hb, exp_p.vb, exp_p.hs, exp_p.vs, exp_p.rgb);
            end
            if (phase == 1 && !first_seen && got.h != 11'd0) begin
                first_seen = 1'b1;
                checks++;
                if (got.h !== 11'd5) begin
                    errors++;
                    $display("FAIL first_hcount got=%0d required=5", got.h);
                end
            end
            if (phase == 7 && got.rgb == 12'hF0F) f0f_count++;
            for (int i = 0; i < NLIT; i++) begin
                if (!lit_seen[i] && phase == lit_ph[i] && int'(got.h) == lit_h[i] && int'(got.v) == lit_v[i]) begin
                    lit_seen[i] = 1'b1;
                    checks++;
                    if (got.rgb !== lit_c[i]) begin
                        errors++;
                        $display("FAIL pixel phase=%0d (%0d,%0d) got=%h required=%h",
                                 phase, lit_h[i], lit_v[i], got.rgb, lit_c[i]);
                    end
                end
            end
        end
    end

    initial begin
        set_lit(0,  2, 100, 50,  12'hF0F);
        set_lit(1,  2, 147, 113, 12'hF0F);
        set_lit(2,  2, 99,  50,  12'h0A0);
        set_lit(3,  2, 148, 50,  12'h0A0);
        set_lit(4,  2, 100, 49,  12'h0A0);
        set_lit(5,  2, 100, 114, 12'h0A0);
        set_lit(6,  3, 780, 580, 12'hF0F);
        set_lit(7,  3, 799, 599, 12'hF0F);
        set_lit(8,  3, 800, 580, 12'h000);
        set_lit(9,  3, 780, 600, 12'h000);
        set_lit(10, 3, 0,   0,   12'h0A0);
        set_lit(11, 3, 779, 580, 12'h0A0);
        set_lit(12, 4, 0,   0,   12'hF0F);
        set_lit(13, 4, 47,  63,  12'hF0F);
        set_lit(14, 4, 48,  0,   12'h0A0);
        set_lit(15, 5, 100, 198, 12'hF0F);
`ifdef DRAW_RECT_FRAME_LATCH_EN
        set_lit(16, 5, 100, 201, 12'hF0F);
        set_lit(17, 5, 300, 201, 12'h0A0);
`else
        set_lit(16, 5, 100, 201, 12'h0A0);
        set_lit(17, 5, 300, 201, 12'hF0F);
`endif
        set_lit(18, 6, 300, 201, 12'hF0F);
        set_lit(19, 6, 100, 201, 12'h0A0);
        set_lit(20, 4, 0,   64,  12'h0A0);

        // Reset held over an active stream, then release
        rst = 1'b0;
        pix(1, 10); pix(2, 10); pix(3, 10);
        rst = 1'b1;
        for (int h = 5; h < 12; h++) pix(h, 10);

        phase = 2;
        start_frame(100, 50);
        for (int v = 48; v <= 115; v++) drive_line(v);

        phase = 3;
        start_frame(780, 580);
        for (int v = 578; v < 628; v++) drive_line(v);
        drive_line(0);
        drive_line(1);

        phase = 4;
        start_frame(0, 0);
        drive_line(0);
        drive_line(63);
        drive_line(64);

        phase = 5;
        start_frame(100, 150);
        for (int v = 198; v <= 200; v++) drive_line(v);
        xpos = 12'd300;
        for (int v = 201; v <= 203; v++) drive_line(v);

        phase = 6;
        start_frame(300, 150);
        for (int v = 198; v <= 203; v++) drive_line(v);

        phase = 7;
        start_frame(12'hFFF, 50);
        for (int v = 0; v < 628; v += 50) drive_full(v);
        start_frame(800, 0);
        drive_full(0);
        start_frame(100, 700);
        drive_full(100);

        // Reset pulse in the middle of a rectangle
        phase = 8;
        bg = 12'h123;
        start_frame(0, 0);
        for (int h = 0; h < 10; h++) pix(h, 0);
        rst = 1'b0;
        pix(10, 0);
        rst = 1'b1;
        for (int h = 11; h < 30; h++) pix(h, 0);
        pix(0, 1); pix(1, 1); pix(2, 1);
        #2;

        checks++;
        if (f0f_count != 0) begin
            errors++;
            $display("FAIL offscreen_f0f got=%0d required=0", f0f_count);
        end
        checks++;
        if (!first_seen) begin
            errors++;
            $display("FAIL first_hcount got=none required=5");
        end
        for (int i = 0; i < NLIT; i++) begin
            if (!lit_seen[i]) begin
                checks++;
                errors++;
                $display("FAIL pixel_missing phase=%0d (%0d,%0d) got=none required=%h",
                         lit_ph[i], lit_h[i], lit_v[i], lit_c[i]);
            end
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/draw_rect.md
# draw_rect

Pipelined overlay stage placed directly downstream of `vga_timing` (or of any background stage fed by it). It consumes a VGA timing/pixel stream, paints a solid rectangle of fixed size at a run-time position over the incoming colour, and forwards the stream with all timing fields delayed to match the colour path. Its output feeds the next draw stage or the board-level RGB/sync pins.

## Interface

Parameters:
- `RECT_W`, 48: rectangle width in pixels, 1..1023
- `RECT_H`, 64: rectangle height in lines, 1..1023
- `RECT_COLOR`, 12'hF_0_F: fill colour, 4:4:4 RGB

Ports:
- `clk`  input  1  pixel clock, 40 MHz; all logic on rising edge
- `rst`  input  1  reset, synchronous, active-low
- `xpos`  input  12  requested left edge, unsigned pixels
- `ypos`  input  12  requested top edge, unsigned lines
- `vga_in`  `vga_if` input modport  fields `hcount`[10:0], `vcount`[10:0], `hblnk`, `vblnk`, `hsync`, `vsync`, `rgb`[11:0]
- `vga_out`  `vga_if` output modport  same fields

## Operation

- Two-stage pipeline, no stalls, one pixel in and one out every cycle.
- Stage 1: register all seven `vga_in` fields; compute `hit` from current `vga_in` counters and active position `(xa, ya)`:
  - `hit = (hcount >= xa) && (hcount < xa + RECT_W) && (vcount >= ya) && (vcount < ya + RECT_H)`
  - Sums formed at 13 bits, zero-extended compares; no wrap. Rectangle extending past the visible area is clipped by blanking, never wraps to column/line 0.
- Stage 2: register timing fields from stage 1; colour:
  - `hblnk_s1 || vblnk_s1` → `rgb = 12'h000`
  - else `hit_s1` → `RECT_COLOR`
  - else `rgb_s1` (pass-through)
- Active position `(xa, ya)` source depends on `DRAW_RECT_FRAME_LATCH_EN` (see Configuration).
- No other state; no FSM beyond the pipeline and the latch edge detector.

## Timing

- Latency: exactly 2 cycles for every field; `vga_out.X(t) = f(vga_in.X(t-2))`. Sync/blank/counter alignment relative to `rgb` preserved.
- Reset (`rst == 0` at a rising edge): all `vga_out` fields 0, both pipeline stages 0, `xa = ya = 0`, `vblnk_prev = 0`. Outputs stay 0 while reset held and for the first 2 cycles after release (pipeline refill).
- Reset mid-frame: takes effect on the next edge; no partial rectangle survives; after release, output resumes with whatever `vga_in` carried 2 cycles earlier.
- `xpos`/`ypos` changes are not synchronised; caller guarantees they are in the `clk` domain.
- Edge cases: `xpos >= 800` or `ypos >= 600` → nothing drawn; `xpos = 0, ypos = 0` → pixel (0,0) coloured; last coloured column is `xa + RECT_W - 1`.

## Configuration

- `DRAW_RECT_FRAME_LATCH_EN` defined: `xa/ya` loaded from `xpos/ypos` only on the cycle where `vga_in.vblnk == 1 && vblnk_prev == 0` (start of vertical blank); held otherwise. Position changes during active video take effect next frame, no tearing. `vblnk_prev` is a register of `vga_in.vblnk`.
- Not defined: `xa = xpos`, `ya = ypos` combinationally every cycle; no latch registers, no edge detector. Mid-frame moves may tear.

## Test plan

- Reset: hold `rst = 0` 3 cycles with active stream → all `vga_out` fields 0; first non-zero `vga_out.hcount` equals `vga_in.hcount` from 2 cycles earlier.
- Latency: background `rgb = 12'h0_A_0`, rect at (100,50) → for every cycle, `vga_out.hsync/vsync/hblnk/vblnk/hcount/vcount` equal `vga_in` values delayed by 2.
- Placement: `xpos = 100, ypos = 50`, defaults → pixels (100..147, 50..113) are 12'hF0F; (99,50), (148,50), (100,49), (100,114) are 12'h0A0.
- Blanking/clip: `xpos = 780, ypos = 580` → columns 780..799 coloured on lines 580..599; all `hblnk`/`vblnk` pixels output 12'h000; nothing drawn at column 0 or line 0.
- Frame latch (macro on): change `xpos` 100 → 300 at line 200 → remainder of frame still at 100; next frame at 300. Macro off: lines ≥ 201 drawn at 300.
- Off-screen: `xpos = 12'hFFF` → no pixel equals 12'hF0F over a full frame.
